// File: rtl/wb_stage.sv
// RV32 write-back stage: retires ALU results and aligned/extended loads onto the regfile write port.
// Define WB_INSTRET_EN to build the 64-bit retired-instruction counter; otherwise instret_o is tied to 0.
module wb_stage #(
  parameter int XLEN     = 32,
  parameter int RADDR_W  = 5,
  parameter int LOAD_TMO = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [RADDR_W-1:0] rd_i,
  input  logic               rd_we_i,
  input  logic               is_load_i,
  input  logic [2:0]         funct3_i,
  input  logic [XLEN-1:0]    result_i,
  input  logic               dmem_rvalid_i,
  input  logic [XLEN-1:0]    dmem_rdata_i,
  output logic               we_o,
  output logic [RADDR_W-1:0] waddr_o,
  output logic [XLEN-1:0]    wdata_o,
  output logic               err_o,
  output logic [63:0]        instret_o
);

  typedef enum logic {IDLE, WAIT} state_e;

  localparam int CNT_W = (LOAD_TMO > 1) ? $clog2(LOAD_TMO + 1) : 1;
  localparam int TMO_LAST_I = (LOAD_TMO > 0) ? LOAD_TMO - 1 : 0;
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_LAST_I[CNT_W-1:0];

  state_e             state_q, state_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic               rd_we_q, rd_we_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [1:0]         off_q, off_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [RADDR_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic               err_q, err_d;

  logic [XLEN-1:0]    shifted;
  logic [XLEN-1:0]    load_val;
  logic               load_fault;

  assign ready_o = (state_q == IDLE);

  // Bring the addressed byte/half down to bit 0, then extend per load type.
  always_comb begin
    shifted    = dmem_rdata_i >> {off_q, 3'b000};
    load_val   = '0;
    load_fault = 1'b0;
    case (funct3_q)
      3'd0: load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'd1: begin
        load_val   = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
        load_fault = off_q[0];
      end
      3'd2: begin
        load_val   = dmem_rdata_i;
        load_fault = (off_q != 2'b00);
      end
      3'd4: load_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'd5: begin
        load_val   = {{(XLEN-16){1'b0}}, shifted[15:0]};
        load_fault = off_q[0];
      end
      default: load_fault = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    rd_we_d  = rd_we_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    err_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        // Load data with no load outstanding is a protocol error, not data.
        if (dmem_rvalid_i) err_d = 1'b1;
        if (valid_i) begin
          if (is_load_i) begin
            rd_d     = rd_i;
            rd_we_d  = rd_we_i;
            funct3_d = funct3_i;
            off_d    = result_i[1:0];
            cnt_d    = '0;
            state_d  = WAIT;
          end else begin
            we_d    = rd_we_i && (rd_i != '0);
            waddr_d = rd_i;
            wdata_d = result_i;
          end
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          state_d = IDLE;
          if (load_fault) begin
            err_d = 1'b1;
          end else begin
            we_d    = rd_we_q && (rd_q != '0);
            waddr_d = rd_q;
            wdata_d = load_val;
          end
        end else if (LOAD_TMO != 0) begin
          if (cnt_q == TMO_LAST) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rd_q     <= '0;
      rd_we_q  <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      rd_we_q  <= rd_we_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  assign we_o    = we_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;
  assign err_o   = err_q;

`ifdef WB_INSTRET_EN
  // Completed loads count even when faulting; timeouts never complete.
  logic        retire;
  logic [63:0] instret_q, instret_d;

  assign retire = ((state_q == IDLE) && valid_i && !is_load_i) ||
                  ((state_q == WAIT) && dmem_rvalid_i);

  always_comb begin
    instret_d = instret_q + {63'd0, retire};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) instret_q <= '0;
    else       instret_q <= instret_d;
  end

  assign instret_o = instret_q;
`else
  assign instret_o = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a transaction-level model predicts each completion and the cycle it
// appears in; a negedge monitor pops and compares, and requires silence on we_o/err_o otherwise.
module tb_wb_stage;

  localparam int TMO = 4;
`ifdef WB_INSTRET_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  rd_i;
  logic        rd_we_i;
  logic        is_load_i;
  logic [2:0]  funct3_i;
  logic [31:0] result_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        err_o;
  logic [63:0] instret_o;

  // 10 ns clock; everything in the DUT lives on the rising edge
  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .RADDR_W(5), .LOAD_TMO(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .rd_i(rd_i), .rd_we_i(rd_we_i), .is_load_i(is_load_i), .funct3_i(funct3_i),
    .result_i(result_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .err_o(err_o),
    .instret_o(instret_o)
  );

  typedef struct {
    int          cyc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        err;
    logic [63:0] instret;
  } exp_t;

  exp_t        expQ[$];
  int          cyc = 0;
  int          nChecks = 0;
  int          nPass = 0;
  bit          monEn = 1'b0;
  logic [63:0] modelInstret = '0;

  // cycle index: outputs registered at edge k are visible while cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  // every comparison funnels through here so the counters stay honest
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    nChecks++;
    if (act === req) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // load semantics from the ISA: pick the byte/half, extend, flag bad type or alignment
  function automatic logic [32:0] loadModel(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] val;
    logic        fault;
    sh    = word >> (8 * int'(off));
    val   = '0;
    fault = 1'b0;
    case (f3)
      3'd0: val = 32'($signed(sh[7:0]));
      3'd1: begin val = 32'($signed(sh[15:0])); fault = off[0]; end
      3'd2: begin val = word; fault = (off != 2'd0); end
      3'd4: val = 32'(sh[7:0]);
      3'd5: begin val = 32'(sh[15:0]); fault = off[0]; end
      default: fault = 1'b1;
    endcase
    return {fault, val};
  endfunction

  task automatic pushExp(input int c, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic err, input bit retires);
    exp_t e;
    if (retires && CNT_EN) modelInstret = modelInstret + 64'd1;
    e.cyc = c; e.we = we; e.waddr = wa; e.wdata = wd; e.err = err; e.instret = modelInstret;
    expQ.push_back(e);
  endtask

  // kind 0: ALU op; kind 1: load with dly empty WAIT cycles before rvalid (dly >= TMO times out)
  task automatic applyStimulus(input int kind, input logic [4:0] rd, input logic rdWe,
                               input logic [2:0] f3, input logic [31:0] res,
                               input logic [31:0] rdata, input int dly);
    logic [32:0] lm;
    int          acc;
    valid_i   = 1'b1;
    is_load_i = (kind == 1);
    rd_i      = rd;
    rd_we_i   = rdWe;
    funct3_i  = f3;
    result_i  = res;
    checkOutput("ready_idle", {63'd0, ready_o}, 64'd1);
    if (kind == 0) begin
      pushExp(cyc + 1, rdWe && (rd != 5'd0), rd, res, 1'b0, 1'b1);
      stepCycle();
      valid_i = 1'b0;
    end else begin
      stepCycle();
      acc       = cyc;
      valid_i   = 1'b0;
      rd_i      = 5'($urandom);
      result_i  = $urandom;
      funct3_i  = 3'($urandom);
      if (dly >= TMO) begin
        pushExp(acc + TMO, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        repeat (TMO) begin
          checkOutput("ready_wait", {63'd0, ready_o}, 64'd0);
          stepCycle();
        end
      end else begin
        repeat (dly) begin
          checkOutput("ready_wait", {63'd0, ready_o}, 64'd0);
          stepCycle();
        end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
        lm = loadModel(f3, res[1:0], rdata);
        checkOutput("ready_wait", {63'd0, ready_o}, 64'd0);
        pushExp(cyc + 1, !lm[32] && rdWe && (rd != 5'd0), rd, lm[31:0], lm[32], 1'b1);
        stepCycle();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = $urandom;
      end
    end
  endtask

  task automatic applyStray();
    valid_i       = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = $urandom;
    pushExp(cyc + 1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    stepCycle();
    dmem_rvalid_i = 1'b0;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_ready", {63'd0, ready_o}, 64'd1);
    checkOutput("rst_we", {63'd0, we_o}, 64'd0);
    checkOutput("rst_err", {63'd0, err_o}, 64'd0);
    checkOutput("rst_waddr", {59'd0, waddr_o}, 64'd0);
    checkOutput("rst_wdata", {32'd0, wdata_o}, 64'd0);
    checkOutput("rst_instret", instret_o, 64'd0);
  endtask

  // monitor: compare the predicted completion for this cycle, otherwise demand a quiet port
  always @(negedge clk) begin
    if (monEn) begin
      if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("we", {63'd0, we_o}, {63'd0, e.we});
        checkOutput("err", {63'd0, err_o}, {63'd0, e.err});
        checkOutput("instret", instret_o, e.instret);
        if (e.we) begin
          checkOutput("waddr", {59'd0, waddr_o}, {59'd0, e.waddr});
          checkOutput("wdata", {32'd0, wdata_o}, {32'd0, e.wdata});
        end
      end else begin
        checkOutput("we_quiet", {63'd0, we_o}, 64'd0);
        checkOutput("err_quiet", {63'd0, err_o}, 64'd0);
      end
    end
  end

  // run directed cases from the datasheet, then a randomized mix
  initial begin
    int r;
    rst_i = 1'b1; valid_i = 1'b0; rd_i = '0; rd_we_i = 1'b0; is_load_i = 1'b0;
    funct3_i = '0; result_i = '0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    repeat (3) stepCycle();
    rst_i = 1'b0;
    checkResetValues();
    monEn = 1'b1;

    applyStimulus(0, 5'd5, 1'b1, 3'd0, 32'h0000_1234, 32'd0, 0);
    applyStimulus(0, 5'd7, 1'b1, 3'd0, 32'hCAFE_0001, 32'd0, 0);
    applyStimulus(1, 5'd9, 1'b1, 3'd0, 32'h0000_1003, 32'h80FF_FF11, 2);
    applyStimulus(1, 5'd10, 1'b1, 3'd5, 32'h0000_2002, 32'hBEEF_0000, 0);
    applyStimulus(1, 5'd11, 1'b1, 3'd2, 32'h0000_3001, 32'h1234_5678, 1);
    applyStimulus(0, 5'd0, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'd0, 0);
    applyStimulus(1, 5'd12, 1'b1, 3'd1, 32'h0000_0002, 32'h8001_0000, 3);
    applyStimulus(1, 5'd13, 1'b1, 3'd2, 32'h0000_0000, 32'hDEAD_BEEF, TMO);
    applyStray();

    // reset while a load is outstanding, then late load data arrives
    valid_i = 1'b1; is_load_i = 1'b1; rd_i = 5'd3; rd_we_i = 1'b1;
    funct3_i = 3'd2; result_i = 32'h0000_0100;
    stepCycle();
    valid_i = 1'b0;
    stepCycle();
    rst_i = 1'b1;
    stepCycle();
    rst_i = 1'b0;
    modelInstret = '0;
    checkResetValues();
    applyStray();

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        applyStimulus(0, 5'($urandom), 1'($urandom), 3'd0, $urandom, 32'd0, 0);
      end else if (r <= 7) begin
        applyStimulus(1, 5'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom,
                      $urandom_range(0, TMO + 1));
      end else if (r == 8) begin
        applyStray();
      end else begin
        stepCycle();
      end
    end

    repeat (3) stepCycle();
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  // watchdog so a wedged run still ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, required < 20000", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
